imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: fills the word-indexed instruction store at runtime from a byte stream (UART RX or debug bridge), replacing file preload.
- Holds the CPU in reset while loading, then releases it.
- Sits between the byte-stream source and the instruction memory write port.

Parameters:
- DEPTH, 1001, number of 32-bit words in the instruction memory (word indices 0..DEPTH-1).
- CNT_W, 16, width of the word-count header field.

Ports:
- SYS_clk  input  1  system clock; all logic on posedge.
- SYS_reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  source presents a byte on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader can accept a byte. A byte transfers on a posedge with rx_valid && rx_ready.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  32  word index (not byte address) for the write.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  holds the CPU in reset while high.
- load_done  output  1  sticky; image fully written.
- load_error  output  1  sticky; bad header, or checksum failure when that feature is enabled.

Behaviour:
- Stream format:
  - Two header bytes give word count N, little-endian: low byte first.
  - Then 4*N payload bytes; each word is little-endian (first byte goes to [7:0]).
- Reset values: state LEN_LO, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0. Internal byte lane = 0, word index = 0, count = 0.
- rx_ready is combinational from state:
  - 1 in LEN_LO, LEN_HI, DATA, CHK.
  - 0 in WRITE, DONE, ERR.
  - When rx_ready=0, rx_valid is ignored; the source must hold its byte until accepted.
- LEN_LO: on accept, count[7:0] <= rx_data; go to LEN_HI.
- LEN_HI: on accept, count[15:8] <= rx_data. Using the full 16-bit count:
  - If count > DEPTH: go to ERR.
  - Else if count == 0: go to DONE (or CHK when the checksum feature is enabled).
  - Else: go to DATA.
- DATA: on accept, the byte is stored in lane byte_idx of the assembly register and byte_idx increments mod 4. When the 4th byte is accepted, go to WRITE.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - Latency: strobe occurs the cycle after the 4th byte is accepted.
  - Next cycle: word index increments. If the new index == count, go to DONE (or CHK); else go to DATA.
- mem_we is 0 in every state except WRITE. mem_addr/mem_wdata hold their last values otherwise.
- DONE: load_done=1, cpu_hold=0. Absorbing until SYS_reset; rx_ready=0 and further bytes are ignored.
- ERR: load_error=1, cpu_hold=1. Absorbing until SYS_reset; no writes are issued.
- Reset mid-load:
  - Aborts immediately: next cycle is state LEN_LO with all reset values.
  - A WRITE in progress in the reset cycle is suppressed (mem_we=0).
  - Words already written stay in memory.
- Boundaries:
  - N == DEPTH is legal; the last write goes to index DEPTH-1.
  - Index never exceeds N-1.
  - A byte offered during WRITE is accepted in the following DATA cycle.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running XOR of all payload bytes (header excluded).
  - After the final WRITE (or directly after the header when N=0), state CHK accepts one byte.
  - Byte equals the XOR: go to DONE. Otherwise: go to ERR.
- Not defined: CHK state and XOR register do not exist; completion goes straight to DONE.

Test Plan:
- Basic load: feed 02 00 13 05 A0 00 93 05 B0 00 -> exactly two mem_we pulses: addr 0 data 0x00A00513, then addr 1 data 0x00B00593. Then load_done=1, cpu_hold=0, rx_ready=0.
- Empty image: 00 00 -> zero mem_we pulses; load_done=1 the cycle after the 2nd byte.
- Oversize header: EA 03 (N=1002 > DEPTH=1001) -> load_error=1, cpu_hold=1, rx_ready=0, no mem_we. Extra bytes are ignored.
- Backpressure: basic image with rx_valid held high continuously -> rx_ready=0 in each WRITE cycle. No byte is lost or duplicated; same two writes result.
- Reset mid-load: assert SYS_reset after 02 00 13 05 A0 00 93 05 -> one write (addr 0) completed, none for addr 1. After reset, state LEN_LO with all outputs at reset values; a fresh basic load then succeeds.
- Checksum (macro defined): basic image followed by 0x90 -> load_done=1. Same image followed by 0x91 -> load_error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills the instruction memory from a byte stream, holding the CPU in reset until done
// Optional trailing XOR checksum byte over the payload: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 1001,
  parameter int CNT_W = 16
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR, CHK} state_t;
  localparam state_t FINISH = CHK;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
  localparam state_t FINISH = DONE;
`endif

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, word_idx, word_idx_inc, header;
  logic [1:0]       byte_idx;
  logic [31:0]      asm_word;
  logic             accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept       = rx_valid && rx_ready;
  assign header       = CNT_W'({rx_data, count[7:0]});
  assign word_idx_inc = word_idx + CNT_W'(1);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state     <= LEN_LO;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_word  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        LEN_LO: if (accept) count[7:0] <= rx_data;
        LEN_HI: if (accept) count <= header;
        DATA: if (accept) begin
          asm_word[{byte_idx, 3'b000} +: 8] <= rx_data;
          byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx_data;
`endif
          // Address and data are latched here so they are stable throughout the WRITE cycle.
          if (byte_idx == 2'd3) begin
            mem_addr  <= 32'(word_idx);
            mem_wdata <= {rx_data, asm_word[23:0]};
          end
        end
        WRITE: word_idx <= word_idx_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) state_n = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          if ({1'b0, header} > DEPTH_C) state_n = ERR;
          else if (header == '0)        state_n = FINISH;
          else                          state_n = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (accept && byte_idx == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        // A reset landing on the strobe cycle must not reach the memory.
        mem_we  = !SYS_reset;
        state_n = (word_idx_inc == count) ? FINISH : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        if (accept) state_n = (rx_data == csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      ERR:     load_error = 1'b1;
      default: state_n = LEN_LO;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Covers both builds; checksum expectations follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  logic        SYS_clk = 1'b0;
  logic        SYS_reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, cpu_hold, load_done, load_error;
  logic [31:0] mem_addr, mem_wdata;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_in_write = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  basic_img[$];
  logic [7:0]  big_img[$];
  logic [7:0]  big_sum;
  int          bad_words;

  always #5 SYS_clk = ~SYS_clk;

  imem_loader dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  // Memory-side log of every write strobe.
  always @(negedge SYS_clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (rx_ready) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    SYS_reset = 1'b1;
    rx_valid  = 1'b0;
    @(negedge SYS_clk);
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    ready_in_write = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      @(negedge SYS_clk);
      waited++;
    end
    check("rx_accept_wait", 32'(waited < 50), 32'd1);
    @(negedge SYS_clk);
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input bit gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (gap) begin
        rx_valid = 1'b0;
        @(negedge SYS_clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_basic_writes(input string tag);
    check({tag, "_nwrites"}, wr_addr.size(), 32'd2);
    check({tag, "_addr0"}, wr_addr[0], 32'd0);
    check({tag, "_data0"}, wr_data[0], 32'h00A00513);
    check({tag, "_addr1"}, wr_addr[1], 32'd1);
    check({tag, "_data1"}, wr_data[1], 32'h00B00593);
  endtask

  initial begin
    basic_img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    basic_img.push_back(8'h90);
`endif
    @(negedge SYS_clk);
    do_reset();

    check("rst_rx_ready", rx_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);

    // Basic load with idle gaps between bytes
    send_stream(basic_img, 1'b1);
    @(negedge SYS_clk);
    check_basic_writes("basic");
    check("basic_done", load_done, 1);
    check("basic_cpu_hold", cpu_hold, 0);
    check("basic_rx_ready", rx_ready, 0);
    check("basic_error", load_error, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (4) @(negedge SYS_clk);
    rx_valid = 1'b0;
    check("done_extra_nwrites", wr_addr.size(), 32'd2);
    check("done_extra_done", load_done, 1);

    // Empty image
    do_reset();
    send_stream('{8'h00, 8'h00}, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("empty_chk_ready", rx_ready, 1);
    send_stream('{8'h00}, 1'b0);
`endif
    check("empty_done", load_done, 1);
    check("empty_nwrites", wr_addr.size(), 32'd0);

    // Oversize header: 1002 words
    do_reset();
    send_stream('{8'hEA, 8'h03}, 1'b0);
    check("over_error", load_error, 1);
    check("over_cpu_hold", cpu_hold, 1);
    check("over_rx_ready", rx_ready, 0);
    check("over_done", load_done, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (4) @(negedge SYS_clk);
    rx_valid = 1'b0;
    check("over_nwrites", wr_addr.size(), 32'd0);
    check("over_error_sticky", load_error, 1);

    // Backpressure: rx_valid held high across the whole image
    do_reset();
    send_stream(basic_img, 1'b0);
    @(negedge SYS_clk);
    check_basic_writes("bp");
    check("bp_ready_in_write", ready_in_write, 0);
    check("bp_done", load_done, 1);

    // Largest legal image: N == DEPTH
    do_reset();
    big_img = '{8'hE9, 8'h03};
    big_sum = 8'h00;
    for (int i = 0; i < 1001; i++) begin
      logic [31:0] w;
      w = 32'hC0DE0000 ^ (i * 32'h00010003);
      for (int k = 0; k < 4; k++) begin
        big_img.push_back(w[8*k +: 8]);
        big_sum ^= w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    big_img.push_back(big_sum);
`endif
    send_stream(big_img, 1'b0);
    @(negedge SYS_clk);
    bad_words = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 32'(i) || wr_data[i] !== (32'hC0DE0000 ^ (i * 32'h00010003))) bad_words++;
    check("max_nwrites", wr_addr.size(), 32'd1001);
    check("max_bad_words", bad_words, 0);
    check("max_last_addr", wr_addr[wr_addr.size() - 1], 32'd1000);
    check("max_done", load_done, 1);

    // Reset mid-load after word 0 and half of word 1
    do_reset();
    send_stream('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05}, 1'b0);
    check("mid_nwrites", wr_addr.size(), 32'd1);
    check("mid_addr0", wr_addr[0], 32'd0);
    do_reset();
    check("mid_rst_rx_ready", rx_ready, 1);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_cpu_hold", cpu_hold, 1);
    check("mid_rst_done", load_done, 0);
    send_stream(basic_img, 1'b0);
    @(negedge SYS_clk);
    check_basic_writes("reload");
    check("reload_done", load_done, 1);

    // Reset arriving on the write strobe cycle
    do_reset();
    send_stream('{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
    check("wr_lat_we", mem_we, 1);
    check("wr_lat_addr", mem_addr, 0);
    check("wr_lat_data", mem_wdata, 32'hEFBEADDE);
    SYS_reset = 1'b1;
    #1;
    check("wr_suppress_we", mem_we, 0);
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    check("wr_suppress_addr", mem_addr, 0);
    check("wr_suppress_data", mem_wdata, 0);
    check("wr_suppress_done", load_done, 0);
    check("wr_suppress_ready", rx_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
